// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// IDLE -> RUN -> DONE handshake with a single-cycle done pulse.
module divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             qbit;
  logic [WIDTH-1:0] prem_next;
  logic [WIDTH-1:0] dq_next;

  // Shifted partial remainder is WIDTH+1 bits; on a successful trial the true
  // difference is below the divisor, so the low WIDTH bits of it are exact.
  always_comb begin
    shifted   = {prem, dq[WIDTH-1]};
    qbit      = (shifted >= {1'b0, dvs});
    diff      = shifted[WIDTH-1:0] - dvs;
    prem_next = qbit ? diff : shifted[WIDTH-1:0];
    dq_next   = {dq[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      prem        <= '0;
      dq          <= '0;
      dvs         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvs         <= divisor;
            dq          <= dividend;
            prem        <= '0;
            cnt         <= CW'(WIDTH);
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          prem <= prem_next;
          dq   <= dq_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= dq_next;
            remainder <= prem_next;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed corner cases plus a random
// operand sweep against a plain-arithmetic reference.
module tb_divider_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp;
  int n_err;
  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;

  divider_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".done"}, 64'(done), 64'd0);
    check({tag, ".q"},    64'(quotient), 64'd0);
    check({tag, ".r"},    64'(remainder), 64'd0);
    check({tag, ".dbz"},  64'(div_by_zero), 64'd0);
  endtask

  // Issue one operation. restart_at: cycle index after acceptance at which a
  // second start is pulsed; reset_at: cycle index at which rst aborts the run;
  // start_in_done: hold start high during the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int restart_at, input int reset_at,
                        input bit start_in_done);
    logic [W-1:0] eq, er;
    logic         edbz;
    int           lat, n;
    bit           seen, held;
    edbz = (b == '0);
    eq   = edbz ? '1 : a / b;
    er   = edbz ? a  : a % b;
    lat  = edbz ? 1 : W + 1;

    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    n = 1; seen = 1'b0; held = 1'b1;
    while (!seen && n <= W + 8) begin
      if (reset_at == n) begin
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
        repeat (3) begin
          @(negedge clk);
          check("rst_no_done", 64'(done), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_done", 64'(done), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        prev_q = '0; prev_r = '0;
        return;
      end
      if (done) begin
        seen = 1'b1;
      end else begin
        if (quotient !== prev_q || remainder !== prev_r) held = 1'b0;
        if (restart_at == n) begin
          start = 1'b1; dividend = $urandom; divisor = $urandom_range(1, 50);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    if (!seen) begin
      check("timeout", 64'd0, 64'd1);
      return;
    end
    check("latency", 64'(n), 64'(lat));
    check("hold", 64'(held), 64'd1);
    check("busy_in_done", 64'(busy), 64'd1);
    check("quotient", 64'(quotient), 64'(eq));
    check("remainder", 64'(remainder), 64'(er));
    check("dbz", 64'(div_by_zero), 64'(edbz));
    if (!edbz) begin
      check("identity", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
      check("rem_lt_div", 64'(remainder < b), 64'd1);
    end
    prev_q = eq; prev_r = er;
    if (start_in_done) begin
      start = 1'b1; dividend = 32'd3; divisor = 32'd1;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("result_kept", 64'(quotient), 64'(eq));
  endtask

  initial begin
    logic [W-1:0] a, b;
    n_cmp = 0; n_err = 0;
    prev_q = '0; prev_r = '0;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(32'd100, 32'd7, 0, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 0, 0, 1'b0);
    run_op(32'd5, 32'd9, 0, 0, 1'b0);
    run_op(32'h1234, 32'd0, 0, 0, 1'b0);
    run_op(32'd77, 32'd0, 0, 0, 1'b1);
    run_op(32'd100, 32'd7, 10, 0, 1'b0);
    run_op(32'd5000, 32'd3, 0, 15, 1'b0);
    run_op(32'd1000, 32'd10, 0, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b1);
    run_op(32'h8000_0000, 32'h8000_0001, 0, 0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 255);
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = a >> $urandom_range(0, 4);
      endcase
      if (b == '0) b = 32'd1;
      run_op(a, b, 0, 0, bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
